// File: rtl/branch_sequencer.sv
// Branch-flag protocol initiator: issues setflag codes to the flag unit, samples
// the returned flag and advances or redirects the program counter.
module branch_sequencer #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] target,
  output logic [2:0]        setflag,
  input  logic              flag,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              taken,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADVANCE = 3'b000;
  localparam logic [2:0] OP_RECORD  = 3'b111;

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] pc_next;

  assign instr_ready = (state == IDLE);
  assign pc_next     = pc + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      target_q    <= '0;
      setflag     <= '0;
      pc          <= RESET_PC;
      pc_valid    <= 1'b0;
      taken       <= 1'b0;
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      pc_valid <= 1'b0;
      taken    <= 1'b0;

      case (state)
        IDLE: begin
          setflag <= '0;
          if (instr_valid) begin
            if (op == OP_ADVANCE) begin
              pc       <= pc_next;
              pc_valid <= 1'b1;
            end else begin
              op_q     <= op;
              target_q <= target;
              setflag  <= op;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: state <= SAMPLE;
        SAMPLE: begin
          state    <= IDLE;
          setflag  <= '0;
          pc_valid <= 1'b1;
          if (op_q == OP_RECORD) begin
            pc <= pc_next;
          end else begin
            taken <= flag;
            pc    <= flag ? target_q : pc_next;
          end
        end
        default: state <= IDLE;
      endcase

      // Clear takes priority over the resolve-edge increment.
      if (stat_clr) begin
        br_count    <= '0;
        taken_count <= '0;
      end else if (state == SAMPLE && op_q != OP_RECORD) begin
        if (br_count != '1)
          br_count <= br_count + CNT_W'(1);
        if (flag && taken_count != '1)
          taken_count <= taken_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with 2-bit counters so saturation is reachable.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  op;
  logic [31:0] target;
  logic [2:0]  setflag;
  logic        flag;
  logic [31:0] pc;
  logic        pc_valid;
  logic        taken;
  logic        stat_clr;
  logic [1:0]  br_count;
  logic [1:0]  taken_count;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;

  branch_sequencer #(
    .ADDR_W  (32),
    .RESET_PC(32'h0),
    .CNT_W   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .op         (op),
    .target     (target),
    .setflag    (setflag),
    .flag       (flag),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .taken      (taken),
    .stat_clr   (stat_clr),
    .br_count   (br_count),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one flag operation from the handshake through the resolve edge (E2);
  // returns #1 after E2. clr raises stat_clr across E2.
  task automatic issue(input logic [2:0] o, input logic [31:0] t, input logic f, input logic clr);
    instr_valid = 1'b1; op = o; target = t;
    step();
    instr_valid = 1'b0; op = 3'b000; flag = f;
    step();
    stat_clr = clr;
    step();
    stat_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; op = '0; target = '0; flag = 1'b0; stat_clr = 1'b0;
    #12;
    total++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", pc); else pass_cnt++;
    total++; if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", instr_ready); else pass_cnt++;
    total++; if (setflag !== 3'b000) $display("FAIL reset_setflag: got %b want 000", setflag); else pass_cnt++;
    total++; if ({pc_valid, taken} !== 2'b00) $display("FAIL reset_valid_taken: got %b want 00", {pc_valid, taken}); else pass_cnt++;
    total++; if ({br_count, taken_count} !== 4'h0) $display("FAIL reset_counts: got %h want 0", {br_count, taken_count}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_advance();
    instr_valid = 1'b1; op = 3'b000;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++; if (pc !== 32'(i)) $display("FAIL adv_pc%0d: got %h want %h", i, pc, 32'(i)); else pass_cnt++;
      total++; if ({pc_valid, taken} !== 2'b10) $display("FAIL adv_flags%0d: got %b want 10", i, {pc_valid, taken}); else pass_cnt++;
      total++; if (setflag !== 3'b000) $display("FAIL adv_setflag%0d: got %b want 000", i, setflag); else pass_cnt++;
    end
    instr_valid = 1'b0;
    step();
    total++; if ({pc, pc_valid} !== {32'h3, 1'b0}) $display("FAIL adv_idle: got pc=%h v=%b want pc=3 v=0", pc, pc_valid); else pass_cnt++;
  endtask

  task automatic test_branch_zero();
    instr_valid = 1'b1; op = 3'b011; target = 32'h40;
    step();
    instr_valid = 1'b0; op = 3'b000; flag = 1'b1;
    total++; if ({setflag, instr_ready} !== {3'b011, 1'b0}) $display("FAIL bz_e0: got sf=%b rdy=%b want 011/0", setflag, instr_ready); else pass_cnt++;
    step();
    total++; if ({setflag, pc_valid, pc} !== {3'b011, 1'b0, 32'h3}) $display("FAIL bz_e1: got sf=%b v=%b pc=%h want 011/0/3", setflag, pc_valid, pc); else pass_cnt++;
    step();
    total++; if (setflag !== 3'b000) $display("FAIL bz_e2_setflag: got %b want 000", setflag); else pass_cnt++;
    total++; if (pc !== 32'h40) $display("FAIL bz_pc: got %h want 40", pc); else pass_cnt++;
    total++; if ({pc_valid, taken, instr_ready} !== 3'b111) $display("FAIL bz_flags: got %b want 111", {pc_valid, taken, instr_ready}); else pass_cnt++;
    total++; if ({br_count, taken_count} !== {2'd1, 2'd1}) $display("FAIL bz_counts: got %0d/%0d want 1/1", br_count, taken_count); else pass_cnt++;
    step();
    total++; if ({pc_valid, taken} !== 2'b00) $display("FAIL bz_pulse_end: got %b want 00", {pc_valid, taken}); else pass_cnt++;
    issue(3'b011, 32'h40, 1'b0, 1'b0);
    total++; if ({pc, pc_valid, taken} !== {32'h41, 1'b1, 1'b0}) $display("FAIL bz_nt: got pc=%h v=%b t=%b want 41/1/0", pc, pc_valid, taken); else pass_cnt++;
    total++; if ({br_count, taken_count} !== {2'd2, 2'd1}) $display("FAIL bz_nt_counts: got %0d/%0d want 2/1", br_count, taken_count); else pass_cnt++;
  endtask

  task automatic test_carry_record();
    issue(3'b111, 32'h77, 1'b1, 1'b0);
    total++; if ({pc, pc_valid, taken} !== {32'h42, 1'b1, 1'b0}) $display("FAIL rec_pc: got pc=%h v=%b t=%b want 42/1/0", pc, pc_valid, taken); else pass_cnt++;
    total++; if ({br_count, taken_count} !== {2'd2, 2'd1}) $display("FAIL rec_counts: got %0d/%0d want 2/1", br_count, taken_count); else pass_cnt++;
    issue(3'b101, 32'h80, 1'b1, 1'b0);
    total++; if ({pc, taken} !== {32'h80, 1'b1}) $display("FAIL bc_pc: got pc=%h t=%b want 80/1", pc, taken); else pass_cnt++;
    total++; if ({br_count, taken_count} !== {2'd3, 2'd2}) $display("FAIL bc_counts: got %0d/%0d want 3/2", br_count, taken_count); else pass_cnt++;
  endtask

  task automatic test_wrap();
    issue(3'b001, 32'hFFFF_FFFF, 1'b1, 1'b0);
    total++; if (pc !== 32'hFFFF_FFFF) $display("FAIL wrap_jump: got %h want ffffffff", pc); else pass_cnt++;
    total++; if ({br_count, taken_count} !== {2'd3, 2'd3}) $display("FAIL wrap_sat: got %0d/%0d want 3/3", br_count, taken_count); else pass_cnt++;
    instr_valid = 1'b1; op = 3'b000;
    step();
    instr_valid = 1'b0;
    total++; if ({pc, pc_valid} !== {32'h0, 1'b1}) $display("FAIL wrap_pc: got pc=%h v=%b want 0/1", pc, pc_valid); else pass_cnt++;
  endtask

  task automatic test_saturation();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    total++; if ({br_count, taken_count} !== 4'h0) $display("FAIL clr_idle: got %0d/%0d want 0/0", br_count, taken_count); else pass_cnt++;
    for (int i = 1; i <= 5; i++) begin
      issue(3'b001, 32'h100 + 32'(i), 1'b1, 1'b0);
      total++; if ({br_count, taken_count} !== {2'(i > 3 ? 3 : i), 2'(i > 3 ? 3 : i)})
        $display("FAIL sat_counts%0d: got %0d/%0d want %0d/%0d", i, br_count, taken_count, (i > 3 ? 3 : i), (i > 3 ? 3 : i));
      else pass_cnt++;
    end
    total++; if (pc !== 32'h105) $display("FAIL sat_pc: got %h want 105", pc); else pass_cnt++;
    issue(3'b001, 32'h200, 1'b1, 1'b1);
    total++; if ({br_count, taken_count} !== 4'h0) $display("FAIL clr_wins: got %0d/%0d want 0/0", br_count, taken_count); else pass_cnt++;
    total++; if (pc !== 32'h200) $display("FAIL clr_pc: got %h want 200", pc); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // instr_valid stays high with op=advance while the branch is in flight.
    instr_valid = 1'b1; op = 3'b100; target = 32'h10;
    step();
    op = 3'b000; flag = 1'b1;
    step();
    total++; if ({pc, pc_valid} !== {32'h200, 1'b0}) $display("FAIL b2b_ignore: got pc=%h v=%b want 200/0", pc, pc_valid); else pass_cnt++;
    step();
    total++; if ({pc, taken} !== {32'h10, 1'b1}) $display("FAIL b2b_branch: got pc=%h t=%b want 10/1", pc, taken); else pass_cnt++;
    step();
    instr_valid = 1'b0;
    total++; if ({pc, pc_valid, taken} !== {32'h11, 1'b1, 1'b0}) $display("FAIL b2b_adv: got pc=%h v=%b t=%b want 11/1/0", pc, pc_valid, taken); else pass_cnt++;
    total++; if ({br_count, taken_count} !== {2'd1, 2'd1}) $display("FAIL b2b_counts: got %0d/%0d want 1/1", br_count, taken_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    instr_valid = 1'b1; op = 3'b001; target = 32'h99;
    step();
    instr_valid = 1'b0; op = 3'b000; flag = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    total++; if ({setflag, pc} !== {3'b000, 32'h0}) $display("FAIL rstmid_pc: got sf=%b pc=%h want 000/0", setflag, pc); else pass_cnt++;
    total++; if ({pc_valid, instr_ready} !== 2'b01) $display("FAIL rstmid_flags: got %b want 01", {pc_valid, instr_ready}); else pass_cnt++;
    total++; if ({br_count, taken_count} !== 4'h0) $display("FAIL rstmid_counts: got %0d/%0d want 0/0", br_count, taken_count); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({pc, pc_valid, setflag} !== {32'h0, 1'b0, 3'b000}) $display("FAIL rstmid_after%0d: got pc=%h v=%b sf=%b want 0/0/000", i, pc, pc_valid, setflag); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_branch_zero();
    test_carry_record();
    test_wrap();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Sequential initiator of the branch-flag protocol: accepts decoded branch and carry-record operations, drives the 3-bit `setflag` code to the combinational flag unit, samples the returned `flag`, and updates the program counter (taken → target, not taken → PC+1). It sits between the instruction decoder and the fetch stage. It also keeps saturating branch and taken counters for performance debug.

## Interface
- `ADDR_W`, 32, program counter and target width
- `RESET_PC`, 0, PC value loaded on reset
- `CNT_W`, 16, width of the statistics counters

- `clk`  in  1  single clock; all state changes on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  decoder presents an operation
- `instr_ready`  out  1  sequencer can accept; high only in IDLE
- `op`  in  3  000 advance, 001 jump, 010 branch-if-negative, 011 branch-if-zero, 100 branch-if-nonzero, 101 branch-if-carry, 110 branch-if-no-carry, 111 record carry
- `target`  in  ADDR_W  branch destination, used when taken
- `setflag`  out  3  registered code to the flag unit
- `flag`  in  1  condition result from the flag unit
- `pc`  out  ADDR_W  current program counter (registered)
- `pc_valid`  out  1  one-cycle pulse: `pc` has just been updated
- `taken`  out  1  valid with `pc_valid`: last update was a taken branch
- `stat_clr`  in  1  synchronous clear of both counters
- `br_count`  out  CNT_W  accepted conditional/unconditional branches (op 001–110)
- `taken_count`  out  CNT_W  branches resolved taken

## Operation
- States: IDLE, ISSUE, SAMPLE.
- `instr_ready` = (state == IDLE). A handshake occurs on an edge where `instr_valid` && `instr_ready`.
- `op` = 000 in IDLE: fast path. `pc` ← `pc`+1 at the handshake edge. `pc_valid`=1 and `taken`=0 for the next cycle. State stays IDLE. No flag transaction.
- `op` ≠ 000: `op` and `target` are captured. State IDLE→ISSUE. `setflag` ← `op`.
- ISSUE→SAMPLE unconditionally. `setflag` is held so the flag unit has a full cycle to settle.
- SAMPLE→IDLE. At this edge `flag` is sampled and `setflag` ← 000.
  - op 001–110: `taken` ← `flag`; `pc` ← `flag` ? `target` : `pc`+1.
  - op 111: the flag unit records carry while `setflag`=111. `taken` ← 0 regardless of `flag`; `pc` ← `pc`+1.
- `pc_valid` is high only in the cycle after a PC update. `taken` is meaningful only while `pc_valid`=1 and is 0 otherwise.
- `setflag` = 000 whenever state is IDLE.
- Arithmetic:
  - `pc`+1 wraps modulo 2^ADDR_W; all-ones → 0.
  - `target` is used as-is with no offset arithmetic.
- Counters:
  - `br_count` increments at the SAMPLE→IDLE edge for op 001–110.
  - `taken_count` increments on the same edge when `flag`=1 for those ops.
  - Both saturate at 2^CNT_W−1.
  - `stat_clr` zeroes both counters and wins over a coincident increment.
- Reset (`rst_n`=0, asynchronous, any state):
  - state IDLE, `pc`=RESET_PC, `setflag`=000, `pc_valid`=0, `taken`=0, counters 0, `instr_ready`=1.
  - An operation in flight is aborted with no PC update and no counter change.
- `instr_valid` during ISSUE/SAMPLE is ignored. The decoder must hold `op`/`target` until the handshake.

## Timing
- Conditional op accepted at edge E0:
  - `setflag`=op in the cycles after E0 and after E1.
  - Sampling and PC update at edge E2.
  - `pc_valid` and `taken` high in the cycle after E2, with `instr_ready`=1 in the same cycle.
- Next handshake possible at E3, so maximum branch throughput is 1 per 3 cycles. Fast-path advance sustains 1 per cycle.
- `flag` must be stable at edge E2. The flag unit is combinational from `setflag` and ALU state.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then op 000 ×3 back-to-back: `pc` goes 0→1→2→3 on consecutive edges, `pc_valid` high 3 cycles, `taken`=0.
- op 011 (branch-if-zero), `target`=0x40, `flag`=1 at E2: `setflag`=011 for 2 cycles then 000, `pc`=0x40, `taken`=1, `br_count`=1, `taken_count`=1. Repeat with `flag`=0: `pc`=0x41, `taken_count` unchanged.
- op 111 with `flag`=1, then op 101 with `flag`=1: first op gives `pc`+1 with `taken`=0 and no counter change; second op is taken.
- `pc`=0xFFFFFFFF, op 000: `pc`=0, `pc_valid`=1.
- With CNT_W=2, issue 5 taken jumps (op 001): both counters hold 3. Assert `stat_clr` on the SAMPLE edge of the next jump: both counters are 0.
- Assert `rst_n`=0 mid-SAMPLE: immediately `setflag`=000, `pc`=RESET_PC, `pc_valid`=0, `instr_ready`=1. No update follows release.
